sc_life_loss_sequencer: RTL and testbench

Control stage directly upstream of the lives register. It turns raw collision levels from the game comparator into single-cycle, active-low life-subtract pulses, and enforces an invulnerability cooldown after each hit. It also issues the clear pulse that restores the lives register at game start, and runs the game-over state from the register's zero-lives flag.

---
 rtl/sc_life_pkg.sv | 11 +
 rtl/sc_rising_edge_detector.sv | 15 +
 rtl/sc_life_loss_sequencer.sv | 58 +++++
 tb/tb_sc_life_loss_sequencer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/sc_life_pkg.sv
// sc_life_pkg: state encoding shared by the life-loss sequencer and its bench.
// OVER takes code 5, the first code after the five ordered play states; 6-7 stay illegal.
package sc_life_pkg;
  localparam int STATE_WIDTH = 3;
  localparam logic [STATE_WIDTH-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_WIDTH-1:0] ST_START    = 3'd1;
  localparam logic [STATE_WIDTH-1:0] ST_PLAY     = 3'd2;
  localparam logic [STATE_WIDTH-1:0] ST_HIT      = 3'd3;
  localparam logic [STATE_WIDTH-1:0] ST_COOLDOWN = 3'd4;
  localparam logic [STATE_WIDTH-1:0] ST_OVER     = 3'd5;
endpackage

// File: rtl/sc_rising_edge_detector.sv
// sc_rising_edge_detector: one-cycle rise flag from a synchronous level.
// Ports: i_clk clock, i_rst async active-high reset, i_level input level,
//        o_rise high when i_level is 1 and was 0 at the previous edge.
module sc_rising_edge_detector (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_rise
);
  logic r_prev;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= i_level;
  assign o_rise = i_level & ~r_prev;
endmodule

// File: rtl/sc_life_loss_sequencer.sv
// sc_life_loss_sequencer: turns collision levels into life-subtract pulses with a cooldown.
// Ports: RegPERDIO_VIDAS_CLOCK_50 clock, RegPERDIO_VIDAS_RESET_InHigh async reset,
//        collision_InHigh collision level, start_game_InLow new-game request,
//        lives_zero_InLow zero-lives flag (0 = none left),
//        substract_life_OutLow / clear_OutLow one-cycle pulses to the lives register,
//        invulnerable_OutHigh cooldown active, game_over_OutHigh in OVER,
//        state_OutBUS current state code.
module sc_life_loss_sequencer
  import sc_life_pkg::*;
#(
  parameter int COOLDOWN_WIDTH  = 26,
  parameter int COOLDOWN_CYCLES = 50000000
) (
  input  logic                   RegPERDIO_VIDAS_CLOCK_50,
  input  logic                   RegPERDIO_VIDAS_RESET_InHigh,
  input  logic                   collision_InHigh,
  input  logic                   start_game_InLow,
  input  logic                   lives_zero_InLow,
  output logic                   substract_life_OutLow,
  output logic                   clear_OutLow,
  output logic                   invulnerable_OutHigh,
  output logic                   game_over_OutHigh,
  output logic [STATE_WIDTH-1:0] state_OutBUS
);
  logic [STATE_WIDTH-1:0]    r_state;
  logic [STATE_WIDTH-1:0]    w_next;
  logic [COOLDOWN_WIDTH-1:0] r_cnt;
  logic                      w_rise;
  sc_rising_edge_detector u_edge (
    .i_clk   (RegPERDIO_VIDAS_CLOCK_50),
    .i_rst   (RegPERDIO_VIDAS_RESET_InHigh),
    .i_level (collision_InHigh),
    .o_rise  (w_rise)
  );
  // Start overrides everything except START itself, so a held start alternates START/PLAY.
  always_comb
    w_next = (!start_game_InLow && r_state != ST_START) ? ST_START :
             (r_state == ST_IDLE)     ? ST_IDLE :
             (r_state == ST_START)    ? ST_PLAY :
             (r_state == ST_PLAY)     ? (!lives_zero_InLow ? ST_OVER : w_rise ? ST_HIT : ST_PLAY) :
             (r_state == ST_HIT)      ? ST_COOLDOWN :
             (r_state == ST_COOLDOWN) ? (!lives_zero_InLow ? ST_OVER :
                                         (r_cnt == '0) ? ST_PLAY : ST_COOLDOWN) :
             (r_state == ST_OVER)     ? ST_OVER : ST_IDLE;
  always_ff @(posedge RegPERDIO_VIDAS_CLOCK_50 or posedge RegPERDIO_VIDAS_RESET_InHigh)
    if (RegPERDIO_VIDAS_RESET_InHigh) r_state <= ST_IDLE;
    else                              r_state <= w_next;
  // Staying in COOLDOWN implies a non-zero count, so the decrement never wraps.
  always_ff @(posedge RegPERDIO_VIDAS_CLOCK_50 or posedge RegPERDIO_VIDAS_RESET_InHigh)
    if (RegPERDIO_VIDAS_RESET_InHigh)                         r_cnt <= '0;
    else if (r_state == ST_HIT && w_next == ST_COOLDOWN)      r_cnt <= COOLDOWN_WIDTH'(COOLDOWN_CYCLES - 1);
    else if (r_state == ST_COOLDOWN && w_next == ST_COOLDOWN) r_cnt <= r_cnt - COOLDOWN_WIDTH'(1);
  assign substract_life_OutLow = (r_state != ST_HIT);
  assign clear_OutLow          = (r_state != ST_START);
  assign invulnerable_OutHigh  = (r_state == ST_HIT) || (r_state == ST_COOLDOWN);
  assign game_over_OutHigh     = (r_state == ST_OVER);
  assign state_OutBUS          = r_state;
endmodule

// File: tb/tb_sc_life_loss_sequencer.sv
// tb_sc_life_loss_sequencer: directed bench with a lives-register model and pulse scoreboard.
module tb_sc_life_loss_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       coll;
  logic       start;
  logic       lives_zero;
  logic       sub;
  logic       clr;
  logic       inv;
  logic       go;
  logic [2:0] state;
  logic [1:0] lives;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         n;
  int         exp_q[$];
  sc_life_loss_sequencer #(.COOLDOWN_WIDTH(4), .COOLDOWN_CYCLES(4)) dut (
    .RegPERDIO_VIDAS_CLOCK_50     (clk),
    .RegPERDIO_VIDAS_RESET_InHigh (rst),
    .collision_InHigh             (coll),
    .start_game_InLow             (start),
    .lives_zero_InLow             (lives_zero),
    .substract_life_OutLow        (sub),
    .clear_OutLow                 (clr),
    .invulnerable_OutHigh         (inv),
    .game_over_OutHigh            (go),
    .state_OutBUS                 (state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or posedge rst)
    if (rst)       lives <= 2'd3;
    else if (!clr) lives <= 2'd3;
    else if (!sub && lives != 0) lives <= lives - 2'd1;
  assign lives_zero = (lives != 0);
  always @(negedge clk)
    if (!sub) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_pulse cycle=%0d expected no pulse", cyc);
      end
      if (exp_q.size() != 0) begin
        automatic int e = exp_q.pop_front();
        total++;
        assert (cyc === e) else begin
          bad++;
          $error("FAIL pulse_cycle got=%0d exp=%0d", cyc, e);
        end
      end
    end
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic hit_start();
    coll = 1'b1;
    exp_q.push_back(cyc + 1);
    step(1);
    coll = 1'b0;
  endtask
  initial begin
    rst = 1'b1; start = 1'b1; coll = 1'b0;
    #1;
    chk("rst_sub", sub, 1); chk("rst_clr", clr, 1); chk("rst_inv", inv, 0);
    chk("rst_go", go, 0); chk("rst_state", state, 0);
    step(2); rst = 1'b0; step(2);
    chk("idle_hold", state, 0);
    start = 1'b0; step(1); start = 1'b1;
    chk("s1_start_state", state, 1); chk("s1_clr_low", clr, 0);
    step(1);
    chk("s1_play_state", state, 2); chk("s1_clr_high", clr, 1); chk("s1_lives", lives, 3);
    coll = 1'b1; exp_q.push_back(cyc + 1); n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      n += int'(inv);
    end
    chk("s2_inv_len", n, 5); chk("s2_lives", lives, 2); chk("s2_play", state, 2);
    coll = 1'b0; step(2);
    hit_start();
    chk("mid_hit_sub", sub, 0);
    step(2);
    chk("mid_cooldown", state, 4); chk("mid_inv", inv, 1);
    start = 1'b0; step(1); start = 1'b1;
    chk("mid_start", state, 1); chk("mid_clr", clr, 0); chk("mid_inv_drop", inv, 0);
    step(1);
    chk("mid_play", state, 2); chk("mid_lives", lives, 3);
    step(1);
    hit_start();
    step(1); coll = 1'b1; step(1); coll = 1'b0; step(2); coll = 1'b1; step(1);
    chk("s3_play", state, 2); chk("s3_lives", lives, 2);
    coll = 1'b0; step(1);
    hit_start(); step(5);
    chk("s3_resume_lives", lives, 1); chk("s3_resume_play", state, 2);
    start = 1'b0; coll = 1'b1; step(1);
    chk("sc_start_wins", state, 1);
    start = 1'b1; step(1);
    chk("sc_play", state, 2);
    coll = 1'b0; step(1);
    chk("sc_no_hit", state, 2); chk("sc_lives", lives, 3);
    hit_start(); step(5); chk("s4_lives2", lives, 2);
    hit_start(); step(5); chk("s4_lives1", lives, 1);
    hit_start(); step(1);
    chk("s4_cooldown", state, 4); chk("s4_go_low", go, 0); chk("s4_lives0", lives, 0);
    step(1);
    chk("s4_go_high", go, 1); chk("s4_inv_off", inv, 0);
    repeat (3) begin
      coll = 1'b1; step(1); coll = 1'b0; step(1);
    end
    chk("s4_go_hold", go, 1); chk("s4_lives_hold", lives, 0);
    start = 1'b0; step(1); start = 1'b1;
    chk("s5_clr", clr, 0); chk("s5_start", state, 1);
    step(1);
    chk("s5_play", state, 2); chk("s5_lives", lives, 3); chk("s5_go", go, 0);
    step(1); coll = 1'b1; step(1);
    chk("s6_hit", state, 3); chk("s6_sub_low", sub, 0);
    rst = 1'b1; #1;
    chk("s6_sub", sub, 1); chk("s6_state", state, 0); chk("s6_clr", clr, 1);
    chk("s6_inv", inv, 0); chk("s6_go", go, 0);
    step(1); rst = 1'b0; coll = 1'b0; step(1);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
